// File: rtl/ref_window_loader_if.sv
// Bundle of the command, frame-memory read port and window handshake
// signals of ref_window_loader.
interface ref_window_loader_if #(
    parameter int ADDR_W = 12,
    parameter int WIN    = 15
);
    localparam int BUF_W = WIN * WIN * 8;

    logic                    start;
    logic signed [8:0]       win_x;
    logic signed [8:0]       win_y;
    logic                    mem_rd_en;
    logic [ADDR_W-1:0]       mem_addr;
    logic [7:0]              mem_rd_data;
    logic [BUF_W-1:0]        win_buffer;
    logic                    win_valid;
    logic                    win_ready;
    logic                    busy;
    logic                    done;

    modport master (
        output start, win_x, win_y, mem_rd_data, win_ready,
        input  mem_rd_en, mem_addr, win_buffer, win_valid, busy, done
    );

    modport slave (
        input  start, win_x, win_y, mem_rd_data, win_ready,
        output mem_rd_en, mem_addr, win_buffer, win_valid, busy, done
    );
endinterface

// File: rtl/ref_window_loader.sv
// Fetches a WIN x WIN edge-clamped reference window from frame memory, one
// byte per cycle, and presents it as a packed buffer with valid/ready.
module ref_window_loader #(
    parameter int FRAME_W = 64,
    parameter int FRAME_H = 64,
    parameter int ADDR_W  = 12,
    parameter int WIN     = 15
) (
    input  logic                clk,
    input  logic                rst,
    ref_window_loader_if.slave  bus
);
    localparam int X_W   = $clog2(FRAME_W);
    localparam int Y_W   = $clog2(FRAME_H);
    localparam int BUF_W = WIN * WIN * 8;
    localparam logic [3:0]        LAST  = 4'(WIN - 1);
    localparam logic signed [9:0] X_MAX = 10'(FRAME_W - 1);
    localparam logic signed [9:0] Y_MAX = 10'(FRAME_H - 1);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HOLD} state_t;

    state_t            state_q, state_d;
    logic [3:0]        row_p0, col_p0;
    logic signed [8:0] org_x, org_y;
    logic signed [9:0] pos_x_p0, pos_y_p0, cx_p0, cy_p0;
    logic              vld_p1;
    logic [7:0]        idx_p1;
    logic              done_q;
    logic [BUF_W-1:0]  win_buf;

    function automatic logic signed [9:0] clamp_coord(input logic signed [9:0] v,
                                                      input logic signed [9:0] hi);
        if (v < 10'sd0)
            return 10'sd0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

    // Issue stage (p0): clamped address for the current (row, col)
    assign pos_x_p0 = $signed({org_x[8], org_x}) + $signed({6'd0, col_p0});
    assign pos_y_p0 = $signed({org_y[8], org_y}) + $signed({6'd0, row_p0});
    assign cx_p0    = clamp_coord(pos_x_p0, X_MAX);
    assign cy_p0    = clamp_coord(pos_y_p0, Y_MAX);

    assign bus.mem_rd_en  = (state_q == FETCH);
    assign bus.mem_addr   = (state_q == FETCH) ? ADDR_W'({cy_p0[Y_W-1:0], cx_p0[X_W-1:0]})
                                               : '0;
    assign bus.win_valid  = (state_q == HOLD);
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
    assign bus.win_buffer = win_buf;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = FETCH;
            FETCH:   if (row_p0 == LAST && col_p0 == LAST) state_d = DRAIN;
            DRAIN:   state_d = HOLD;
            HOLD:    if (bus.win_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_p0  <= '0;
            col_p0  <= '0;
            vld_p1  <= 1'b0;
            idx_p1  <= '0;
            done_q  <= 1'b0;
            win_buf <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == HOLD) && bus.win_ready;
            vld_p1  <= (state_q == FETCH);
            idx_p1  <= 8'(row_p0) * 8'(WIN) + 8'(col_p0);
            if (state_q == IDLE && bus.start) begin
                row_p0 <= '0;
                col_p0 <= '0;
            end else if (state_q == FETCH && !(row_p0 == LAST && col_p0 == LAST)) begin
                if (col_p0 == LAST) begin
                    col_p0 <= '0;
                    row_p0 <= row_p0 + 4'd1;
                end else begin
                    col_p0 <= col_p0 + 4'd1;
                end
            end
            // Capture stage (p1): byte returned for the read issued last cycle
            if (vld_p1)
                win_buf[{idx_p1, 3'b000} +: 8] <= bus.mem_rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == IDLE && bus.start) begin
            org_x <= bus.win_x;
            org_y <= bus.win_y;
        end
    end
endmodule

// File: tb/tb_ref_window_loader.sv
// Directed bench for ref_window_loader against a frame memory holding
// mem[a] = a[7:0] with one cycle read latency.
module tb_ref_window_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ref_window_loader_if #(.ADDR_W(12), .WIN(15)) bus ();

    ref_window_loader #(.FRAME_W(64), .FRAME_H(64), .ADDR_W(12), .WIN(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (bus.mem_rd_en) bus.mem_rd_data <= bus.mem_addr[7:0];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int r, input int c);
        return bus.win_buffer[8*c + 120*r +: 8];
    endfunction

    function automatic logic [7:0] model_pix(input int ox, input int oy, input int r, input int c);
        int x, y;
        x = ox + c;
        y = oy + r;
        if (x < 0) x = 0;
        if (x > 63) x = 63;
        if (y < 0) y = 0;
        if (y > 63) y = 63;
        return 8'(y * 64 + x);
    endfunction

    task automatic pulse_start(input int ox, input int oy);
        @(negedge clk);
        bus.win_x = 9'(ox);
        bus.win_y = 9'(oy);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_valid(output int edges, output int rd_cnt);
        edges  = 0;
        rd_cnt = 0;
        while (!bus.win_valid && edges < 400) begin
            if (bus.mem_rd_en) rd_cnt++;
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic check_window(input string tag, input int ox, input int oy);
        int bad = 0;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++)
                if (pix(r, c) !== model_pix(ox, oy, r, c)) bad++;
        check_val(tag, 32'(bad), 32'd0);
    endtask

    task automatic accept();
        @(negedge clk);
        bus.win_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.win_ready = 1'b0;
        check_val("done_high",  32'(bus.done),      32'd1);
        check_val("valid_drop", 32'(bus.win_valid), 32'd0);
        check_val("busy_drop",  32'(bus.busy),      32'd0);
        @(posedge clk);
        #1;
        check_val("done_single", 32'(bus.done), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_rd_en"}, 32'(bus.mem_rd_en),   32'd0);
        check_val({tag, "_addr"},  32'(bus.mem_addr),    32'd0);
        check_val({tag, "_valid"}, 32'(bus.win_valid),   32'd0);
        check_val({tag, "_busy"},  32'(bus.busy),        32'd0);
        check_val({tag, "_done"},  32'(bus.done),        32'd0);
        check_val({tag, "_buf"},   32'(|bus.win_buffer), 32'd0);
    endtask

    initial begin
        int edges, rd_cnt, bad, n;
        logic [1799:0] saved;

        bus.start       = 1'b0;
        bus.win_x       = '0;
        bus.win_y       = '0;
        bus.win_ready   = 1'b0;
        bus.mem_rd_data = '0;

        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Interior window with latency measurement
        pulse_start(10, 20);
        wait_valid(edges, rd_cnt);
        check_val("rd_count",      32'(rd_cnt), 32'd225);
        check_val("valid_latency", 32'(edges),  32'd226);
        check_val("t1_pix00",      32'(pix(0, 0)),   32'h0A);
        check_val("t1_pix1414",    32'(pix(14, 14)), 32'h98);
        check_window("t1_window", 10, 20);
        accept();

        // Top-left clamping, then a stalled hold with ignored start pulses
        pulse_start(-3, -3);
        wait_valid(edges, rd_cnt);
        bad = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pix(r, c) !== 8'h00) bad++;
        check_val("t2_corner_zero", 32'(bad), 32'd0);
        check_val("t2_pix55",       32'(pix(5, 5)), 32'h82);
        check_window("t2_window", -3, -3);
        saved = bus.win_buffer;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.start = (i % 2 == 0);
            bus.win_x = 9'd0;
            bus.win_y = 9'd0;
            @(posedge clk);
            #1;
            if (bus.win_buffer !== saved || bus.win_valid !== 1'b1 ||
                bus.mem_rd_en !== 1'b0 || bus.busy !== 1'b1) bad++;
        end
        bus.start = 1'b0;
        check_val("hold_stable", 32'(bad), 32'd0);
        accept();
        check_val("hold_start_ignored", 32'(bus.busy), 32'd0);

        // Bottom-right clamping
        pulse_start(60, 60);
        wait_valid(edges, rd_cnt);
        check_val("t3_pix1414", 32'(pix(14, 14)), 32'hFF);
        check_val("t3_pix00",   32'(pix(0, 0)),   32'h3C);
        check_window("t3_window", 60, 60);
        accept();

        // Asynchronous reset in the middle of a fetch
        pulse_start(10, 20);
        n = 0;
        edges = 0;
        while (n < 100 && edges < 400) begin
            if (bus.mem_rd_en) n++;
            @(posedge clk);
            #1;
            edges++;
        end
        check_val("reads_before_rst", 32'(n), 32'd100);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulse_start(0, 0);
        wait_valid(edges, rd_cnt);
        check_val("t4_valid",  32'(bus.win_valid), 32'd1);
        check_val("t4_pix10",  32'(pix(1, 0)),     32'h40);
        check_window("t4_window", 0, 0);
        accept();

        // Back-to-back: start and ready held high
        @(negedge clk);
        bus.win_x     = 9'd0;
        bus.win_y     = 9'd5;
        bus.start     = 1'b1;
        bus.win_ready = 1'b1;
        n = 0;
        while (!bus.done && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_val("b2b_done1",       32'(bus.done),      32'd1);
        check_val("b2b_done1_rd_en", 32'(bus.mem_rd_en), 32'd0);
        @(posedge clk);
        #1;
        check_val("b2b_refetch", 32'(bus.mem_rd_en), 32'd1);
        check_val("b2b_done1_single", 32'(bus.done), 32'd0);
        n = 0;
        while (!bus.done && n < 600) begin
            @(posedge clk);
            #1;
            n++;
        end
        bus.start     = 1'b0;
        bus.win_ready = 1'b0;
        check_val("b2b_done2", 32'(bus.done), 32'd1);
        check_window("b2b_window", 0, 5);
        @(posedge clk);
        #1;
        check_val("b2b_done2_single", 32'(bus.done), 32'd0);
        check_val("b2b_idle",         32'(bus.busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ref_window_loader.md
Name: ref_window_loader

Overview:
- Upstream feeder for subpixel_interpolation.
- On command, fetches a 15x15 integer-pixel reference window from frame memory, one byte per cycle, with HEVC-style edge clamping (padding) for out-of-frame coordinates.
- Assembles the window into the 1800-bit packed buffer that the interpolator consumes on in_buffer.
- Presents the window with a valid/ready handshake.

Parameters:
- FRAME_W, 64, frame width in pixels (power of 2)
- FRAME_H, 64, frame height in pixels (power of 2)
- ADDR_W, 12, memory address width = log2(FRAME_W*FRAME_H)
- WIN, 15, window side in pixels (fixed; buffer width = WIN*WIN*8 = 1800)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  fetch request; sampled only in IDLE
- win_x  in  9  signed window-origin column (top-left); may be negative or beyond frame
- win_y  in  9  signed window-origin row
- mem_rd_en  out  1  memory read strobe
- mem_addr  out  ADDR_W  read address = row*FRAME_W + col
- mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
- win_buffer  out  1800  packed window; pixel (r,c) at bits [8*c + 120*r +: 8]
- win_valid  out  1  window complete and stable
- win_ready  in  1  consumer accepts the window
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse in the cycle after a valid&ready transfer

Behaviour:
- Reset: asynchronous, active-high.
  - Clears state to IDLE.
  - Outputs go to: win_buffer=0, win_valid=0, mem_rd_en=0, mem_addr=0, busy=0, done=0.
  - Counters go to 0.
  - Reset mid-fetch or mid-hold discards all progress; there is no resume.
- States: IDLE, FETCH, DRAIN, HOLD.
- IDLE:
  - When start=1 at an edge, latch win_x/win_y, clear r,c counters, go to FETCH.
  - start while not in IDLE is ignored; it is neither queued nor does it restart the fetch.
- FETCH:
  - Each cycle: mem_rd_en=1 and mem_addr = clampY(win_y+r)*FRAME_W + clampX(win_x+c), where clamp(v) = min(max(v,0), dim-1).
  - Arithmetic is signed 10-bit, so no wraparound is possible for the 9-bit inputs.
  - Counters run row-major: c increments 0..14, then wraps to 0 and increments r.
  - After issuing (r,c)=(14,14), go to DRAIN.
- Capture:
  - Byte for read k (row-major index) is written into win_buffer at the edge one cycle after it was issued.
  - Uses a one-stage delayed copy of the (r,c) index.
- DRAIN:
  - mem_rd_en=0; captures the final byte, then goes to HOLD.
- Latency: with start sampled at edge E0:
  - mem_rd_en is high for exactly 225 consecutive cycles, following E0 through E225.
  - win_valid rises after E226.
- HOLD:
  - win_valid=1; win_buffer held constant.
  - On win_valid & win_ready at an edge: go to IDLE, win_valid=0, done=1 for one cycle.
  - start sampled in the same cycle as the transfer is ignored; start is accepted from the following IDLE cycle.
- Buffer handling:
  - win_buffer is not cleared between fetches; every byte is overwritten on each fetch.
  - Contents are undefined for consumers while busy and win_valid=0.
- win_ready while not in HOLD has no effect.

Test Plan:
- Memory model mem[a]=a[7:0]; origin (10,20); win_ready=1 → win_buffer[7:0]=0x0A (addr 1290) and win_buffer[1799:1792]=0x98 (addr 2200); done pulses once.
- Origin (-3,-3) → pixels (0..3,0..3) all 0x00 (addr 0); pixel (5,5) is 0x82 (addr 130), located at bits [8*5+120*5 +: 8].
- Origin (60,60) → pixels with r,c ≥ 3 clamp to row/col 63; pixel (14,14)=0xFF (addr 4095); pixel (0,0)=0x3C (addr 3900).
- Latency/handshake:
  - Count mem_rd_en cycles = 225.
  - win_valid rises exactly 226 edges after start.
  - Hold win_ready=0 for 10 cycles: win_buffer unchanged, win_valid stays 1, mem_rd_en stays 0, start pulses in this window are ignored.
- Assert rst for one cycle after the 100th read → all outputs 0 immediately (asynchronous); a new start with origin (0,0) yields a correct full window (pixel (1,0)=0x40).
- Back-to-back: start held high continuously → second fetch begins the cycle after done; done pulses exactly once per transfer.
